huff_merge_sort: RTL and testbench
==================================

# huff_merge_sort

Sequential sort-and-merge stage for the Huffman flow, sitting directly downstream of the symbol counter (`CNTcounter`). When started, it latches the six 15-bit node entries, sorts them ascending by count, and merges the two smallest nodes. It returns the four survivors (`CNT1_n..CNT4_n`) and the merged node (`sum`, `flag`) to the counter, and it accumulates the per-symbol Huffman code words across merges.

## Interface
Parameters:
- `N_SYM`, 6: number of symbols and node slots; fixed at 6.
- `CW`, 8: count field width.
- `FW`, 7: flag field width. Bit 6 is the valid bit; bits 5..0 are the symbol set, with symbol k at bit 6-k.

Ports (one per line: name, direction, width, meaning):
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: request one merge; accepted only in IDLE.
- `clear`, in, 1: synchronous flush, asserted in the counter's finish state.
- `CNT1`..`CNT6`, in, 15 each: node entry, `{count[14:7], flag[6:0]}`.
- `CNT1_n`..`CNT4_n`, out, 15 each: sorted survivors s2..s5.
- `sum`, out, 8: s0.count + s1.count.
- `flag`, out, 7: s0.flag | s1.flag.
- `done`, out, 1: one-cycle pulse; outputs are valid.
- `busy`, out, 1: high in any state other than IDLE.
- `all_merged`, out, 1: five merges have completed.
- `HC1`..`HC6`, out, 8 each: code word per symbol, LSB = first bit assigned.
- `M1`..`M6`, out, 4 each: code length per symbol.

## Operation
- FSM states: IDLE, SORT, MERGE.
- IDLE:
  - `start` with `all_merged`=0: latch `CNT1..CNT6` into array a[0..5] in slot order, clear the pass counter, go to SORT.
  - Otherwise `start` is ignored.
- SORT: six passes of odd-even transposition, one pass per cycle.
  - Even pass compares (0,1), (2,3), (4,5).
  - Odd pass compares (1,2), (3,4).
  - Swap only when a[i].count > a[i+1].count. This is a stable sort, so ties keep slot order.
  - After pass 5, go to MERGE.
- MERGE (one cycle):
  - `CNTk_n` <= a[k+1] for k = 1..4.
  - `sum` <= a0.count + a1.count, 8-bit with carry dropped. Upstream guarantees the total count is at most 255.
  - `flag` <= a0.flag | a1.flag.
  - For each symbol i in a0.flag[5:0]: HCi[Mi] <= 1, Mi <= Mi+1.
  - For each symbol i in a1.flag[5:0]: HCi[Mi] <= 0, Mi <= Mi+1.
  - Merge counter increments; `done` <= 1; go to IDLE.
- Invalid entry is 15'h7F80 (count 255, flag 0). It sorts last and contributes no symbols.
- `all_merged` sets when the merge counter reaches 5 and holds until `clear` or `reset`.
- Priority: `reset` > `clear` > FSM. `clear` zeroes everything `reset` zeroes and returns the FSM to IDLE from any state, including mid-SORT; no `done` is issued.

## Timing
- Reset values: all `CNTk_n`, `sum`, `flag`, `HC*`, `M*` = 0; `done`, `busy`, `all_merged` = 0; FSM = IDLE.
- With `start` sampled at edge t:
  - `busy` is high from t+1 through t+7.
  - `done` is high from edge t+7 to t+8.
  - Outputs update at t+7 and hold until the next MERGE, `clear` or `reset`.
- Start-to-done latency is 7 cycles. The next `start` is accepted at edge t+8 at the earliest; the counter holds `pe` for the single cycle in which `done`=1.
- `start` while busy is ignored, with no queuing.
- `CNT1..CNT6` are sampled only at the accepting edge and may change afterwards.

## Structure
- Package `huff_pkg` holds:
  - entry field positions and widths;
  - `INVALID_ENTRY` = 15'h7F80;
  - `VALID_BIT` = 6;
  - the FSM state encoding;
  - `N_PASS` = 6 and `N_MERGE` = 5.
- Sub-module `huff_cmp_swap`: a combinational compare-exchange of two entries with a strict greater-than swap. Instantiate it 3 times (even pass) and 2 times (odd pass), or 3 times with muxed inputs.

## Test plan
- Reset, then idle: every output is 0 and `busy` = 0.
- Counts 10, 20, 5, 15, 30, 20 with initial flags (1100000 .. 1000001), then `start`:
  - `done` at t+7.
  - `sum` = 15, `flag` = 1101000.
  - `CNT1_n..CNT4_n` = {15, 1000100}, {20, 1010000}, {20, 1000001}, {30, 1000010}.
  - HC3 = 1, M3 = 1; HC1 = 0, M1 = 1.
- All counts 0 → slot order kept: `sum` = 0, `flag` = 1110000, HC1 = 1, HC2 = 0, M1 = M2 = 1.
- Five chained merges, with outputs fed back through the counter model (CNT5 = 15'h7F80, CNT6 = {sum, flag}):
  - `all_merged` = 1 after the fifth `done`.
  - Sum of M1..M6 equals the reference Huffman total length.
  - A sixth `start` is ignored.
- `start` pulsed at t+3 while busy → ignored, and exactly one `done` at t+7.
- `clear` at t+4 mid-SORT → IDLE at t+5, no `done`, codes and lengths zeroed, next `start` accepted normally.

Source files
------------

// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman sort-and-merge stage.
//   Entry layout : {count[14:7], flag[6:0]}
//   Flag layout  : bit 6 = valid, bits 5..0 = symbol set (symbol k at bit 6-k)
package huff_pkg;

  localparam int CNT_W   = 8;
  localparam int FLG_W   = 7;
  localparam int ENT_W   = CNT_W + FLG_W;
  localparam int CNT_LSB = FLG_W;
  localparam int FLG_LSB = 0;
  localparam int HC_W    = 8;
  localparam int LEN_W   = 4;

  localparam logic [ENT_W-1:0] INVALID_ENTRY = 15'h7F80;
  localparam int VALID_BIT = 6;

  localparam int N_PASS  = 6;
  localparam int N_MERGE = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SORT  = 2'd1,
    ST_MERGE = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] entry_count(input logic [ENT_W-1:0] e);
    return e[ENT_W-1:CNT_LSB];
  endfunction

  function automatic logic [FLG_W-1:0] entry_flag(input logic [ENT_W-1:0] e);
    return e[CNT_LSB-1:FLG_LSB];
  endfunction

endpackage

// File: rtl/huff_cmp_swap.sv
// Combinational compare-exchange of two node entries.
//   ent_a, ent_b : entries in slot order (ent_a is the lower slot)
//   lower, upper : ent_a/ent_b reordered so lower.count <= upper.count
// Swaps only on strict greater-than, so equal counts keep slot order.
module huff_cmp_swap
  import huff_pkg::*;
(
  input  logic [ENT_W-1:0] ent_a,
  input  logic [ENT_W-1:0] ent_b,
  output logic [ENT_W-1:0] lower,
  output logic [ENT_W-1:0] upper
);

  logic swap;

  assign swap  = entry_count(ent_a) > entry_count(ent_b);
  assign lower = swap ? ent_b : ent_a;
  assign upper = swap ? ent_a : ent_b;

endmodule

// File: rtl/huff_merge_sort.sv
// Sequential sort-and-merge stage for the Huffman flow.
// On an accepted start the six node entries are latched, sorted ascending by
// count with six odd-even transposition passes, and the two smallest nodes are
// merged. Survivors and the merged node go back to the symbol counter, and
// per-symbol code words/lengths accumulate across merges.
//   clk, reset       : clock, synchronous active-high reset
//   start            : request one merge (IDLE only, ignored once all_merged)
//   clear            : synchronous flush of all state and outputs
//   CNT1..CNT6       : node entries {count, flag}
//   CNT1_n..CNT4_n   : sorted survivors s2..s5
//   sum, flag        : merged node (s0 + s1 counts, s0 | s1 flags)
//   done             : one-cycle pulse when outputs update
//   busy             : FSM not in IDLE
//   all_merged       : five merges completed
//   HC1..HC6, M1..M6 : code word (LSB first) and code length per symbol
module huff_merge_sort
  import huff_pkg::*;
#(
  parameter int N_SYM = 6,
  parameter int CW    = 8,
  parameter int FW    = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic [CW+FW-1:0]  CNT1,
  input  logic [CW+FW-1:0]  CNT2,
  input  logic [CW+FW-1:0]  CNT3,
  input  logic [CW+FW-1:0]  CNT4,
  input  logic [CW+FW-1:0]  CNT5,
  input  logic [CW+FW-1:0]  CNT6,
  output logic [CW+FW-1:0]  CNT1_n,
  output logic [CW+FW-1:0]  CNT2_n,
  output logic [CW+FW-1:0]  CNT3_n,
  output logic [CW+FW-1:0]  CNT4_n,
  output logic [CW-1:0]     sum,
  output logic [FW-1:0]     flag,
  output logic              done,
  output logic              busy,
  output logic              all_merged,
  output logic [HC_W-1:0]   HC1,
  output logic [HC_W-1:0]   HC2,
  output logic [HC_W-1:0]   HC3,
  output logic [HC_W-1:0]   HC4,
  output logic [HC_W-1:0]   HC5,
  output logic [HC_W-1:0]   HC6,
  output logic [LEN_W-1:0]  M1,
  output logic [LEN_W-1:0]  M2,
  output logic [LEN_W-1:0]  M3,
  output logic [LEN_W-1:0]  M4,
  output logic [LEN_W-1:0]  M5,
  output logic [LEN_W-1:0]  M6
);

  localparam int EW = CW + FW;

  state_t           state, state_nxt;
  logic [2:0]       pass_cnt;
  logic [2:0]       merge_cnt;
  logic             accept;
  logic             odd_pass;

  logic [EW-1:0]    a      [N_SYM];
  logic [EW-1:0]    a_pass [N_SYM];
  logic [EW-1:0]    cs_a   [3];
  logic [EW-1:0]    cs_b   [3];
  logic [EW-1:0]    cs_lo  [3];
  logic [EW-1:0]    cs_hi  [3];

  logic [EW-1:0]    cnt_n  [4];
  logic [HC_W-1:0]  hc     [N_SYM];
  logic [LEN_W-1:0] len    [N_SYM];

  logic [CW-1:0]    c0, c1;
  logic [FW-1:0]    f0, f1;

  // Counts are bounded upstream, so the carry out of the add is simply dropped.
  function automatic logic [CW-1:0] merge_sum(input logic [CW-1:0] x,
                                              input logic [CW-1:0] y);
    return x + y;
  endfunction

  assign accept   = (state == ST_IDLE) && start && !all_merged;
  assign odd_pass = pass_cnt[0];
  assign busy     = (state != ST_IDLE);

  assign c0 = a[0][EW-1:FW];
  assign c1 = a[1][EW-1:FW];
  assign f0 = a[0][FW-1:0];
  assign f1 = a[1][FW-1:0];

  // Three compare-exchange units shared by both pass parities; on odd passes
  // the third unit's result is unused and slots 0 and 5 pass straight through.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      cs_a[j] = a[2*j];
      cs_b[j] = a[2*j+1];
    end
    if (odd_pass) begin
      cs_a[0] = a[1];
      cs_b[0] = a[2];
      cs_a[1] = a[3];
      cs_b[1] = a[4];
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_cs
    huff_cmp_swap u_cs (
      .ent_a (cs_a[g]),
      .ent_b (cs_b[g]),
      .lower (cs_lo[g]),
      .upper (cs_hi[g])
    );
  end

  always_comb begin
    for (int i = 0; i < N_SYM; i++) a_pass[i] = a[i];
    if (odd_pass) begin
      a_pass[1] = cs_lo[0];
      a_pass[2] = cs_hi[0];
      a_pass[3] = cs_lo[1];
      a_pass[4] = cs_hi[1];
    end else begin
      for (int j = 0; j < 3; j++) begin
        a_pass[2*j]   = cs_lo[j];
        a_pass[2*j+1] = cs_hi[j];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SORT;
      ST_SORT:  if (pass_cnt == 3'(N_PASS - 1)) state_nxt = ST_MERGE;
      ST_MERGE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state    <= ST_IDLE;
      pass_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pass_cnt <= (state == ST_SORT) ? pass_cnt + 3'd1 : 3'd0;
    end
  end

  // Working array: pure data, loaded on accept and rewritten each sort pass.
  always_ff @(posedge clk) begin
    if (accept) begin
      a[0] <= CNT1;
      a[1] <= CNT2;
      a[2] <= CNT3;
      a[3] <= CNT4;
      a[4] <= CNT5;
      a[5] <= CNT6;
    end else if (state == ST_SORT) begin
      for (int i = 0; i < N_SYM; i++) a[i] <= a_pass[i];
    end
  end

  // Merge stage: survivors, merged node and code-word accumulation.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int k = 0; k < 4; k++) cnt_n[k] <= '0;
      for (int i = 0; i < N_SYM; i++) begin
        hc[i]  <= '0;
        len[i] <= '0;
      end
      sum        <= '0;
      flag       <= '0;
      done       <= 1'b0;
      all_merged <= 1'b0;
      merge_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (state == ST_MERGE) begin
        for (int k = 0; k < 4; k++) cnt_n[k] <= a[k+2];
        sum  <= merge_sum(c0, c1);
        flag <= f0 | f1;
        // Smallest node's symbols get a 1, second smallest a 0, at the next
        // free bit position of each symbol's code word.
        for (int i = 0; i < N_SYM; i++) begin
          if (f0[VALID_BIT-1-i]) begin
            hc[i][len[i][2:0]] <= 1'b1;
            len[i]             <= len[i] + 4'd1;
          end else if (f1[VALID_BIT-1-i]) begin
            hc[i][len[i][2:0]] <= 1'b0;
            len[i]             <= len[i] + 4'd1;
          end
        end
        merge_cnt <= merge_cnt + 3'd1;
        if (merge_cnt == 3'(N_MERGE - 1)) all_merged <= 1'b1;
        done <= 1'b1;
      end
    end
  end

  assign CNT1_n = cnt_n[0];
  assign CNT2_n = cnt_n[1];
  assign CNT3_n = cnt_n[2];
  assign CNT4_n = cnt_n[3];

  assign HC1 = hc[0];
  assign HC2 = hc[1];
  assign HC3 = hc[2];
  assign HC4 = hc[3];
  assign HC5 = hc[4];
  assign HC6 = hc[5];

  assign M1 = len[0];
  assign M2 = len[1];
  assign M3 = len[2];
  assign M4 = len[3];
  assign M5 = len[4];
  assign M6 = len[5];

endmodule

// File: tb/tb_huff_merge_sort.sv
// Bench for huff_merge_sort: directed and random merges checked against a
// list-based Huffman merge model (stable insertion sort of the six slots).
module tb_huff_merge_sort;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [14:0] cnt_in  [6];
  logic [14:0] cnt_out [4];
  logic [7:0]  sum;
  logic [6:0]  flag;
  logic        done, busy, all_merged;
  logic [7:0]  hc [6];
  logic [3:0]  ml [6];

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [7:0]  md_cnt [6];
  logic [6:0]  md_flg [6];
  logic [7:0]  md_hc  [6];
  logic [3:0]  md_len [6];
  logic [14:0] ex_surv [4];
  logic [7:0]  ex_sum;
  logic [6:0]  ex_flag;
  int          md_total;

  huff_merge_sort dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .CNT1(cnt_in[0]), .CNT2(cnt_in[1]), .CNT3(cnt_in[2]),
    .CNT4(cnt_in[3]), .CNT5(cnt_in[4]), .CNT6(cnt_in[5]),
    .CNT1_n(cnt_out[0]), .CNT2_n(cnt_out[1]), .CNT3_n(cnt_out[2]), .CNT4_n(cnt_out[3]),
    .sum(sum), .flag(flag), .done(done), .busy(busy), .all_merged(all_merged),
    .HC1(hc[0]), .HC2(hc[1]), .HC3(hc[2]), .HC4(hc[3]), .HC5(hc[4]), .HC6(hc[5]),
    .M1(ml[0]), .M2(ml[1]), .M3(ml[2]), .M4(ml[3]), .M5(ml[4]), .M6(ml[5])
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [59:0] dut_surv();
    return {cnt_out[0], cnt_out[1], cnt_out[2], cnt_out[3]};
  endfunction
  function automatic logic [47:0] dut_hc();
    return {hc[0], hc[1], hc[2], hc[3], hc[4], hc[5]};
  endfunction
  function automatic logic [23:0] dut_len();
    return {ml[0], ml[1], ml[2], ml[3], ml[4], ml[5]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      md_hc[i]  = '0;
      md_len[i] = '0;
    end
    md_total = 0;
  endtask

  // Symbol i+1 in slot i, valid bit set; counts either random or given.
  task automatic load_symbols(input bit rnd);
    for (int i = 0; i < 6; i++) begin
      md_flg[i] = 7'b1000000 | (7'b0100000 >> i);
      if (rnd) md_cnt[i] = 8'($urandom_range(0, 40));
    end
  endtask

  // One Huffman step: stable sort by count, merge the two smallest, extend the
  // code words of their symbols, then rebuild the slots as the counter would.
  task automatic model_merge();
    logic [7:0] c [6];
    logic [6:0] f [6];
    logic [7:0] tc;
    logic [6:0] tf;
    int j;
    for (int i = 0; i < 6; i++) begin
      c[i] = md_cnt[i];
      f[i] = md_flg[i];
    end
    for (int i = 1; i < 6; i++) begin
      tc = c[i];
      tf = f[i];
      j  = i - 1;
      while (j >= 0) begin
        if (c[j] <= tc) break;
        c[j+1] = c[j];
        f[j+1] = f[j];
        j--;
      end
      c[j+1] = tc;
      f[j+1] = tf;
    end
    ex_sum  = c[0] + c[1];
    ex_flag = f[0] | f[1];
    for (int k = 0; k < 4; k++) ex_surv[k] = {c[k+2], f[k+2]};
    for (int s = 0; s < 6; s++) begin
      if (f[0][5-s]) begin
        md_hc[s][md_len[s][2:0]] = 1'b1;
        md_len[s]++;
        md_total++;
      end else if (f[1][5-s]) begin
        md_hc[s][md_len[s][2:0]] = 1'b0;
        md_len[s]++;
        md_total++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      md_cnt[k] = c[k+2];
      md_flg[k] = f[k+2];
    end
    md_cnt[4] = 8'hFF;
    md_flg[4] = 7'd0;
    md_cnt[5] = ex_sum;
    md_flg[5] = ex_flag;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_surv"}, 64'(dut_surv()),
        64'({ex_surv[0], ex_surv[1], ex_surv[2], ex_surv[3]}));
    chk({tag, "_sum"},  64'(sum),  64'(ex_sum));
    chk({tag, "_flag"}, 64'(flag), 64'(ex_flag));
    chk({tag, "_hc"},   64'(dut_hc()),
        64'({md_hc[0], md_hc[1], md_hc[2], md_hc[3], md_hc[4], md_hc[5]}));
    chk({tag, "_len"},  64'(dut_len()),
        64'({md_len[0], md_len[1], md_len[2], md_len[3], md_len[4], md_len[5]}));
  endtask

  task automatic run_merge(input string tag);
    int k_done;
    int n_done;
    bit busy_ok;
    for (int i = 0; i < 6; i++) cnt_in[i] = {md_cnt[i], md_flg[i]};
    model_merge();
    start = 1'b1;
    tick();
    start   = 1'b0;
    busy_ok = busy;
    k_done  = 0;
    n_done  = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k <= 6 && !busy) busy_ok = 1'b0;
      if (k >= 7 && busy)  busy_ok = 1'b0;
      if (done) begin
        n_done++;
        if (k_done == 0) k_done = k;
      end
    end
    chk({tag, "_latency"}, 64'(k_done), 64'd7);
    chk({tag, "_ndone"},   64'(n_done), 64'd1);
    chk({tag, "_busy"},    64'(busy_ok), 64'd1);
    check_outputs(tag);
  endtask

  initial begin
    int n_done;
    int n_busy;
    int k_done;
    int msum;

    for (int i = 0; i < 6; i++) cnt_in[i] = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_allm", 64'(all_merged), 64'd0);
    chk("rst_data", 64'({sum, flag, dut_surv()}), 64'd0);
    chk("rst_codes", 64'({dut_hc(), dut_len()}), 64'd0);

    // Worked example
    model_reset();
    load_symbols(1'b0);
    md_cnt[0] = 8'd10; md_cnt[1] = 8'd20; md_cnt[2] = 8'd5;
    md_cnt[3] = 8'd15; md_cnt[4] = 8'd30; md_cnt[5] = 8'd20;
    run_merge("example");
    chk("ex_sum_const",  64'(sum), 64'd15);
    chk("ex_flag_const", 64'(flag), 64'(7'b1101000));
    chk("ex_surv_const", 64'(dut_surv()),
        64'({8'd15, 7'b1000100, 8'd20, 7'b1010000, 8'd20, 7'b1000001, 8'd30, 7'b1000010}));
    chk("ex_hc3", 64'({hc[2], ml[2]}), 64'({8'd1, 4'd1}));
    chk("ex_hc1", 64'({hc[0], ml[0]}), 64'({8'd0, 4'd1}));
    chk("ex_allm", 64'(all_merged), 64'd0);

    // All counts equal: ties keep slot order
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    load_symbols(1'b0);
    for (int i = 0; i < 6; i++) md_cnt[i] = 8'd0;
    run_merge("zeros");
    chk("zeros_sum_const",  64'(sum), 64'd0);
    chk("zeros_flag_const", 64'(flag), 64'(7'b1110000));
    chk("zeros_hc12", 64'({hc[0], hc[1]}), 64'({8'd1, 8'd0}));
    chk("zeros_m12",  64'({ml[0], ml[1]}), 64'({4'd1, 4'd1}));

    // Random five-merge chains through the counter feedback
    for (int r = 0; r < 2; r++) begin
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_codes", 64'({dut_hc(), dut_len()}), 64'd0);
      chk("clr_allm",  64'(all_merged), 64'd0);
      model_reset();
      load_symbols(1'b1);
      for (int m = 1; m <= 5; m++) begin
        run_merge($sformatf("chain%0d_m%0d", r, m));
        chk($sformatf("chain%0d_allm%0d", r, m), 64'(all_merged), 64'(m == 5));
      end
      msum = ml[0] + ml[1] + ml[2] + ml[3] + ml[4] + ml[5];
      chk("chain_total_len", 64'(msum), 64'(md_total));
      // Sixth start is ignored
      start = 1'b1;
      tick();
      start  = 1'b0;
      n_done = 0;
      n_busy = busy;
      for (int k = 1; k <= 10; k++) begin
        tick();
        n_done += done;
        n_busy += busy;
      end
      chk("sixth_done", 64'(n_done), 64'd0);
      chk("sixth_busy", 64'(n_busy), 64'd0);
      chk("sixth_hold", 64'({sum, flag}), 64'({ex_sum, ex_flag}));
    end

    // Start pulse while busy is dropped
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
    load_symbols(1'b1);
    for (int i = 0; i < 6; i++) cnt_in[i] = {md_cnt[i], md_flg[i]};
    model_merge();
    start = 1'b1;
    tick();
    start  = 1'b0;
    n_done = 0;
    k_done = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (done) begin
        n_done++;
        if (k_done == 0) k_done = k;
      end
      if (k == 2) begin
        start = 1'b1;
        for (int i = 0; i < 6; i++) cnt_in[i] = 15'($urandom);
      end
      if (k == 3) start = 1'b0;
    end
    chk("busy_start_ndone", 64'(n_done), 64'd1);
    chk("busy_start_lat",   64'(k_done), 64'd7);
    check_outputs("busy_start");

    // Clear in the middle of sorting
    for (int i = 0; i < 6; i++) cnt_in[i] = {md_cnt[i], md_flg[i]};
    start = 1'b1;
    tick();
    start  = 1'b0;
    n_done = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_done += done;
      if (k == 3) clear = 1'b1;
      if (k == 4) begin
        clear = 1'b0;
        chk("clr_mid_idle4", 64'(busy), 64'd0);
      end
      if (k == 5) chk("clr_mid_idle5", 64'(busy), 64'd0);
    end
    chk("clr_mid_ndone", 64'(n_done), 64'd0);
    chk("clr_mid_codes", 64'({dut_hc(), dut_len()}), 64'd0);
    chk("clr_mid_data",  64'({sum, flag, dut_surv()}), 64'd0);
    model_reset();
    load_symbols(1'b1);
    run_merge("after_clear");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
